pio_fifo: RTL and testbench

- System-side endpoint of the state machine's push/pull interface.
- TX FIFO: the system writes words; the state machine drains them with `pull` strobes.
- RX FIFO: the state machine fills it with `push` strobes; the system reads it.
- Single clock domain. The integration layer converts pclk-domain push/pull into single-cycle `clk` strobes.

---
 rtl/pio_fifo_if.sv | 54 +++++
 rtl/pio_fifo.sv | 124 ++++++++++++
 tb/tb_pio_fifo.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_fifo_if.sv
// Push/pull bus between pio_fifo, the system side and the state machine.
// PIO_FIFO_JOIN_EN adds the join_en control and widens the level fields by one bit.
interface pio_fifo_if #(parameter int DEPTH = 4);
`ifdef PIO_FIFO_JOIN_EN
  localparam int LW = $clog2(DEPTH) + 2;
`else
  localparam int LW = $clog2(DEPTH) + 1;
`endif

  logic          sys_wr;
  logic [31:0]   sys_wdata;
  logic          sys_rd;
  logic [31:0]   sys_rdata;
  logic          sys_rvalid;
  logic          tx_full;
  logic          tx_empty;
  logic [LW-1:0] tx_level;
  logic          rx_full;
  logic          rx_empty;
  logic [LW-1:0] rx_level;
  logic          pull;
  logic [31:0]   pull_data;
  logic          pull_valid;
  logic          push;
  logic [31:0]   push_data;
  logic          push_ok;
  logic          err_clr;
  logic          tx_overflow;
  logic          tx_underflow;
  logic          rx_overflow;
`ifdef PIO_FIFO_JOIN_EN
  logic          join_en;
`endif

  modport master (
    output sys_wr, sys_wdata, sys_rd, pull, push, push_data, err_clr,
`ifdef PIO_FIFO_JOIN_EN
    output join_en,
`endif
    input  sys_rdata, sys_rvalid, tx_full, tx_empty, tx_level,
    input  rx_full, rx_empty, rx_level, pull_data, pull_valid, push_ok,
    input  tx_overflow, tx_underflow, rx_overflow
  );

  modport slave (
    input  sys_wr, sys_wdata, sys_rd, pull, push, push_data, err_clr,
`ifdef PIO_FIFO_JOIN_EN
    input  join_en,
`endif
    output sys_rdata, sys_rvalid, tx_full, tx_empty, tx_level,
    output rx_full, rx_empty, rx_level, pull_data, pull_valid, push_ok,
    output tx_overflow, tx_underflow, rx_overflow
  );
endinterface

// File: rtl/pio_fifo.sv
// System-side TX/RX FIFO pair for the state machine push/pull interface.
// PIO_FIFO_JOIN_EN: join_en=1 chains RX storage behind TX (2*DEPTH-entry TX, RX disabled).
module pio_fifo #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  pio_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef PIO_FIFO_JOIN_EN
  localparam int LW = AW + 2;
`else
  localparam int LW = AW + 1;
`endif
  localparam logic [LW-1:0] CAP = LW'(DEPTH);

  // TX owns slots [0, DEPTH), RX owns [DEPTH, 2*DEPTH); joined TX spans all of them.
  logic [31:0]   mem [2*DEPTH];
  logic [LW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [LW-1:0] tx_lvl, rx_lvl, tx_cap;
  logic [AW:0]   tx_widx, tx_ridx, rx_widx, rx_ridx;
  logic          joined, flush;
  logic          tx_full_c, tx_empty_c, rx_full_c, rx_empty_c;
  logic          tx_do_wr, tx_do_rd, rx_do_wr, rx_do_rd;
  logic [31:0]   sys_rdata_q, pull_data_q;
  logic          sys_rvalid_q, pull_valid_q, push_ok_q;
  logic          tx_ovf_q, tx_udf_q, rx_ovf_q;

`ifdef PIO_FIFO_JOIN_EN
  logic join_q;

  always_ff @(posedge clk) begin
    if (reset) join_q <= 1'b0;
    else       join_q <= bus.join_en;
  end

  // Mode follows the registered copy so status always matches pointer state.
  assign joined  = join_q;
  assign flush   = bus.join_en != join_q;
  assign tx_cap  = joined ? LW'(2 * DEPTH) : CAP;
  assign tx_widx = joined ? tx_wr[AW:0] : {1'b0, tx_wr[AW-1:0]};
  assign tx_ridx = joined ? tx_rd[AW:0] : {1'b0, tx_rd[AW-1:0]};
`else
  assign joined  = 1'b0;
  assign flush   = 1'b0;
  assign tx_cap  = CAP;
  assign tx_widx = {1'b0, tx_wr[AW-1:0]};
  assign tx_ridx = {1'b0, tx_rd[AW-1:0]};
`endif
  assign rx_widx = {1'b1, rx_wr[AW-1:0]};
  assign rx_ridx = {1'b1, rx_rd[AW-1:0]};

  assign tx_lvl     = tx_wr - tx_rd;
  assign rx_lvl     = rx_wr - rx_rd;
  assign tx_full_c  = tx_lvl == tx_cap;
  assign tx_empty_c = tx_lvl == '0;
  assign rx_full_c  = joined || (rx_lvl == CAP);
  assign rx_empty_c = joined || (rx_lvl == '0);

  // All decisions use start-of-cycle occupancy; a flush cycle ignores strobes.
  assign tx_do_wr = bus.sys_wr && !tx_full_c  && !flush;
  assign tx_do_rd = bus.pull   && !tx_empty_c && !flush;
  assign rx_do_wr = bus.push   && !rx_full_c  && !flush;
  assign rx_do_rd = bus.sys_rd && !rx_empty_c && !flush;

  always_ff @(posedge clk) begin
    if (tx_do_wr) mem[tx_widx] <= bus.sys_wdata;
    if (rx_do_wr) mem[rx_widx] <= bus.push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr        <= '0;
      tx_rd        <= '0;
      rx_wr        <= '0;
      rx_rd        <= '0;
      sys_rdata_q  <= '0;
      pull_data_q  <= '0;
      sys_rvalid_q <= 1'b0;
      pull_valid_q <= 1'b0;
      push_ok_q    <= 1'b0;
      tx_ovf_q     <= 1'b0;
      tx_udf_q     <= 1'b0;
      rx_ovf_q     <= 1'b0;
    end else begin
      sys_rvalid_q <= rx_do_rd;
      pull_valid_q <= tx_do_rd;
      push_ok_q    <= rx_do_wr;
      if (tx_do_rd) pull_data_q <= mem[tx_ridx];
      if (rx_do_rd) sys_rdata_q <= mem[rx_ridx];
      if (flush) begin
        tx_wr <= '0;
        tx_rd <= '0;
        rx_wr <= '0;
        rx_rd <= '0;
      end else begin
        if (tx_do_wr) tx_wr <= tx_wr + 1'b1;
        if (tx_do_rd) tx_rd <= tx_rd + 1'b1;
        if (rx_do_wr) rx_wr <= rx_wr + 1'b1;
        if (rx_do_rd) rx_rd <= rx_rd + 1'b1;
      end
      // New error events win over a same-cycle clear.
      tx_ovf_q <= (tx_ovf_q && !bus.err_clr) || (bus.sys_wr && tx_full_c  && !flush);
      tx_udf_q <= (tx_udf_q && !bus.err_clr) || (bus.pull   && tx_empty_c && !flush);
      rx_ovf_q <= (rx_ovf_q && !bus.err_clr) || (bus.push   && rx_full_c  && !flush);
    end
  end

  assign bus.tx_full      = tx_full_c;
  assign bus.tx_empty     = tx_empty_c;
  assign bus.tx_level     = tx_lvl;
  assign bus.rx_full      = rx_full_c;
  assign bus.rx_empty     = rx_empty_c;
  assign bus.rx_level     = joined ? '0 : rx_lvl;
  assign bus.sys_rdata    = sys_rdata_q;
  assign bus.sys_rvalid   = sys_rvalid_q;
  assign bus.pull_data    = pull_data_q;
  assign bus.pull_valid   = pull_valid_q;
  assign bus.push_ok      = push_ok_q;
  assign bus.tx_overflow  = tx_ovf_q;
  assign bus.tx_underflow = tx_udf_q;
  assign bus.rx_overflow  = rx_ovf_q;
endmodule

// File: tb/tb_pio_fifo.sv
// Scoreboard bench for pio_fifo: expected words queued when driven, popped when the DUT returns them.
module tb_pio_fifo;
  localparam int DEPTH = 4;
`ifdef PIO_FIFO_JOIN_EN
  localparam int LW = $clog2(DEPTH) + 2;
`else
  localparam int LW = $clog2(DEPTH) + 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];

  pio_fifo_if #(.DEPTH(DEPTH)) bus ();
  pio_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.sys_wr = 0; bus.sys_rd = 0; bus.pull = 0; bus.push = 0; bus.err_clr = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); reset = 0;
    bus.sys_wr = 1; bus.sys_wdata = 32'h55; tick(); tick(); bus.sys_wr = 0;
    bus.push = 1; bus.push_data = 32'h66; tick(); bus.push = 0;
    reset = 1; tick(); reset = 0;
    n_tests++;
    if ({bus.tx_empty, bus.rx_empty, bus.tx_full, bus.rx_full} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 1100", {bus.tx_empty, bus.rx_empty, bus.tx_full, bus.rx_full});
    end
    n_tests++;
    if (bus.tx_level !== LW'(0) || bus.rx_level !== LW'(0)) begin
      n_fail++; $display("FAIL reset_levels: got tx=%0d rx=%0d expected 0 0", bus.tx_level, bus.rx_level);
    end
    n_tests++;
    if (bus.pull_data !== 32'h0 || bus.sys_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got pull=%h rd=%h expected 0 0", bus.pull_data, bus.sys_rdata);
    end
    n_tests++;
    if ({bus.pull_valid, bus.sys_rvalid, bus.push_ok, bus.tx_overflow, bus.tx_underflow, bus.rx_overflow} !== 6'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 000000",
        {bus.pull_valid, bus.sys_rvalid, bus.push_ok, bus.tx_overflow, bus.tx_underflow, bus.rx_overflow});
    end
  endtask

  task automatic pull_check(input string name);
    logic [31:0] e;
    e = tx_q.pop_front();
    bus.pull = 1; tick(); bus.pull = 0;
    n_tests++;
    if (bus.pull_valid !== 1'b1 || bus.pull_data !== e) begin
      n_fail++; $display("FAIL %s: got valid=%b data=%h expected valid=1 data=%h", name, bus.pull_valid, bus.pull_data, e);
    end
    tick();
    n_tests++;
    if (bus.pull_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_pulse: got valid=%b expected 0", name, bus.pull_valid);
    end
  endtask

  task automatic fill_tx(input logic [31:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      bus.sys_wr = 1; bus.sys_wdata = base + 32'(i); tx_q.push_back(base + 32'(i)); tick();
    end
    bus.sys_wr = 0;
  endtask

  task automatic test_tx_fill_drain();
    fill_tx(32'hA0);
    n_tests++;
    if (bus.tx_full !== 1'b1 || bus.tx_level !== LW'(DEPTH)) begin
      n_fail++; $display("FAIL tx_full_level: got full=%b level=%0d expected 1 %0d", bus.tx_full, bus.tx_level, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) pull_check("tx_drain");
    n_tests++;
    if (bus.tx_empty !== 1'b1) begin
      n_fail++; $display("FAIL tx_empty_after_drain: got %b expected 1", bus.tx_empty);
    end
  endtask

  task automatic test_underflow();
    bus.pull = 1; tick(); bus.pull = 0;
    n_tests++;
    if (bus.pull_valid !== 1'b0 || bus.tx_underflow !== 1'b1 || bus.pull_data !== 32'hA3) begin
      n_fail++; $display("FAIL underflow: got valid=%b udf=%b data=%h expected 0 1 a3", bus.pull_valid, bus.tx_underflow, bus.pull_data);
    end
    bus.err_clr = 1; tick(); bus.err_clr = 0;
    n_tests++;
    if (bus.tx_underflow !== 1'b0) begin
      n_fail++; $display("FAIL err_clr: got udf=%b expected 0", bus.tx_underflow);
    end
    bus.err_clr = 1; bus.pull = 1; tick(); idle();
    n_tests++;
    if (bus.tx_underflow !== 1'b1) begin
      n_fail++; $display("FAIL set_wins: got udf=%b expected 1", bus.tx_underflow);
    end
    bus.err_clr = 1; tick(); idle();
    // Write plus pull on empty TX: no bypass, write is stored.
    bus.sys_wr = 1; bus.sys_wdata = 32'hCC; bus.pull = 1; tick(); idle();
    tx_q.push_back(32'hCC);
    n_tests++;
    if (bus.pull_valid !== 1'b0 || bus.tx_underflow !== 1'b1 || bus.tx_level !== LW'(1)) begin
      n_fail++; $display("FAIL wr_pull_empty: got valid=%b udf=%b level=%0d expected 0 1 1", bus.pull_valid, bus.tx_underflow, bus.tx_level);
    end
    pull_check("wr_pull_empty_data");
    bus.err_clr = 1; tick(); idle();
  endtask

  task automatic test_tx_full_wr_pull();
    logic [31:0] e;
    fill_tx(32'hA0);
    e = tx_q.pop_front();
    bus.sys_wr = 1; bus.sys_wdata = 32'hBB; bus.pull = 1; tick(); idle();
    n_tests++;
    if (bus.pull_valid !== 1'b1 || bus.pull_data !== e || bus.tx_overflow !== 1'b1 || bus.tx_level !== LW'(DEPTH - 1)) begin
      n_fail++; $display("FAIL full_wr_pull: got valid=%b data=%h ovf=%b level=%0d expected 1 %h 1 %0d",
        bus.pull_valid, bus.pull_data, bus.tx_overflow, bus.tx_level, e, DEPTH - 1);
    end
    for (int i = 0; i < DEPTH - 1; i++) pull_check("full_wr_pull_drain");
    n_tests++;
    if (bus.tx_empty !== 1'b1) begin
      n_fail++; $display("FAIL bb_dropped: got empty=%b expected 1", bus.tx_empty);
    end
    bus.err_clr = 1; tick(); idle();
  endtask

  task automatic test_back_to_back();
    bus.sys_wr = 1; bus.sys_wdata = 32'h70; tx_q.push_back(32'h70); tick();
    for (int i = 1; i <= 5; i++) begin
      logic [31:0] e;
      e = tx_q.pop_front();
      bus.sys_wdata = 32'h70 + 32'(i); bus.pull = 1; tx_q.push_back(32'h70 + 32'(i)); tick();
      n_tests++;
      if (bus.pull_valid !== 1'b1 || bus.pull_data !== e || bus.tx_level !== LW'(1)) begin
        n_fail++; $display("FAIL tx_b2b: got valid=%b data=%h level=%0d expected 1 %h 1", bus.pull_valid, bus.pull_data, bus.tx_level, e);
      end
    end
    idle();
    pull_check("tx_b2b_tail");
  endtask

  task automatic read_check(input string name);
    logic [31:0] e;
    e = rx_q.pop_front();
    bus.sys_rd = 1; tick(); bus.sys_rd = 0;
    n_tests++;
    if (bus.sys_rvalid !== 1'b1 || bus.sys_rdata !== e) begin
      n_fail++; $display("FAIL %s: got valid=%b data=%h expected valid=1 data=%h", name, bus.sys_rvalid, bus.sys_rdata, e);
    end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.push = 1; bus.push_data = 32'h10 + 32'(i); tick();
      if (i < DEPTH) rx_q.push_back(32'h10 + 32'(i));
      n_tests++;
      if (bus.push_ok !== (i < DEPTH)) begin
        n_fail++; $display("FAIL push_ok_%0d: got %b expected %b", i, bus.push_ok, (i < DEPTH));
      end
    end
    bus.push = 0;
    n_tests++;
    if (bus.rx_overflow !== 1'b1 || bus.rx_full !== 1'b1) begin
      n_fail++; $display("FAIL rx_overflow: got ovf=%b full=%b expected 1 1", bus.rx_overflow, bus.rx_full);
    end
    bus.err_clr = 1; tick(); idle();
    for (int i = 0; i < DEPTH; i++) read_check("rx_read");
    tick();
    bus.sys_rd = 1; tick(); bus.sys_rd = 0;
    n_tests++;
    if (bus.rx_empty !== 1'b1 || bus.sys_rvalid !== 1'b0 || bus.rx_overflow !== 1'b0 || bus.sys_rdata !== 32'h13) begin
      n_fail++; $display("FAIL rx_empty_read: got empty=%b valid=%b ovf=%b data=%h expected 1 0 0 13",
        bus.rx_empty, bus.sys_rvalid, bus.rx_overflow, bus.sys_rdata);
    end
  endtask

  task automatic test_rx_wrap();
    for (int i = 0; i < 2; i++) begin
      bus.push = 1; bus.push_data = 32'h20 + 32'(i); rx_q.push_back(32'h20 + 32'(i)); tick();
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = rx_q.pop_front();
      bus.push = 1; bus.sys_rd = 1; bus.push_data = 32'h30 + 32'(i); rx_q.push_back(32'h30 + 32'(i)); tick();
      n_tests++;
      if (bus.sys_rvalid !== 1'b1 || bus.sys_rdata !== e || bus.rx_level !== LW'(2) || bus.push_ok !== 1'b1) begin
        n_fail++; $display("FAIL rx_wrap_%0d: got valid=%b data=%h level=%0d ok=%b expected 1 %h 2 1",
          i, bus.sys_rvalid, bus.sys_rdata, bus.rx_level, bus.push_ok, e);
      end
    end
    idle();
    read_check("rx_wrap_tail");
    read_check("rx_wrap_tail");
    tick();
    n_tests++;
    if (bus.rx_empty !== 1'b1) begin
      n_fail++; $display("FAIL rx_wrap_empty: got %b expected 1", bus.rx_empty);
    end
  endtask

`ifdef PIO_FIFO_JOIN_EN
  task automatic test_join();
    bus.join_en = 1; tick();
    n_tests++;
    if (bus.rx_full !== 1'b1 || bus.rx_empty !== 1'b1 || bus.rx_level !== LW'(0)) begin
      n_fail++; $display("FAIL join_rx_status: got full=%b empty=%b level=%0d expected 1 1 0", bus.rx_full, bus.rx_empty, bus.rx_level);
    end
    for (int i = 0; i < 2 * DEPTH; i++) begin
      bus.sys_wr = 1; bus.sys_wdata = 32'hD0 + 32'(i); tx_q.push_back(32'hD0 + 32'(i)); tick();
    end
    n_tests++;
    if (bus.tx_full !== 1'b1 || bus.tx_level !== LW'(2 * DEPTH) || bus.tx_overflow !== 1'b0) begin
      n_fail++; $display("FAIL join_fill: got full=%b level=%0d ovf=%b expected 1 %0d 0", bus.tx_full, bus.tx_level, bus.tx_overflow, 2 * DEPTH);
    end
    bus.sys_wdata = 32'hEE; tick(); bus.sys_wr = 0;
    bus.push = 1; bus.push_data = 32'h99; tick(); bus.push = 0;
    n_tests++;
    if (bus.tx_overflow !== 1'b1 || bus.rx_overflow !== 1'b1 || bus.push_ok !== 1'b0) begin
      n_fail++; $display("FAIL join_reject: got txovf=%b rxovf=%b ok=%b expected 1 1 0", bus.tx_overflow, bus.rx_overflow, bus.push_ok);
    end
    for (int i = 0; i < DEPTH + 1; i++) pull_check("join_data");
    bus.join_en = 0; tick();
    tx_q.delete();
    n_tests++;
    if (bus.tx_empty !== 1'b1 || bus.rx_empty !== 1'b1 || bus.rx_full !== 1'b0 || bus.tx_level !== LW'(0) || bus.tx_overflow !== 1'b1) begin
      n_fail++; $display("FAIL join_flush: got txe=%b rxe=%b rxf=%b lvl=%0d ovf=%b expected 1 1 0 0 1",
        bus.tx_empty, bus.rx_empty, bus.rx_full, bus.tx_level, bus.tx_overflow);
    end
  endtask
`endif

  initial begin
    idle();
    bus.sys_wdata = 0; bus.push_data = 0;
`ifdef PIO_FIFO_JOIN_EN
    bus.join_en = 0;
`endif
    test_reset();
    test_tx_fill_drain();
    test_underflow();
    test_tx_full_wr_pull();
    test_back_to_back();
    test_rx_overflow();
    test_rx_wrap();
`ifdef PIO_FIFO_JOIN_EN
    test_join();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
